puf_uart_framer: RTL and testbench

PUF_UART_FRAMER -- requirements
Module: puf_uart_framer

---
 rtl/puf_uart_pkg.sv | 19 +
 rtl/uart_tx_core.sv | 107 ++++++++++
 rtl/puf_uart_framer.sv | 122 ++++++++++++
 tb/tb_puf_uart_framer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_uart_pkg.sv
// Shared types and helpers for the PUF response UART framer.
package puf_uart_pkg;

  localparam int UART_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } ser_state_t;

  function automatic int bytes_per_word(input int resp_width);
    return resp_width / UART_BITS;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Bit-level UART serializer: START, 8 data bits LSB first, optional PARITY, STOP.
// Even parity is added when PUF_UART_PARITY_EN is defined.
module uart_tx_core
  import puf_uart_pkg::*;
#(
  parameter int BAUD_DIV = 1250
) (
  input  logic       clk,
  input  logic       reset_btn,
  input  logic [7:0] tx_byte,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       uart_tx
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  ser_state_t      state_reg;
  logic [CW-1:0]   baud_cnt_reg;
  logic [2:0]      bit_idx_reg;
  logic [7:0]      shift_reg;
  logic            tx_reg;
`ifdef PUF_UART_PARITY_EN
  logic            parity_reg;
`endif

  logic baud_tick;
  assign baud_tick = (baud_cnt_reg == CW'(BAUD_DIV - 1));

  // Accepting during the last STOP cycle lets bytes of a word run gap-free.
  assign byte_ready = (state_reg == IDLE) || ((state_reg == STOP) && baud_tick);
  assign uart_tx    = tx_reg;

  always_ff @(posedge clk or posedge reset_btn) begin
    if (reset_btn) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
`ifdef PUF_UART_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      if ((state_reg == IDLE) || baud_tick) begin
        baud_cnt_reg <= '0;
      end else begin
        baud_cnt_reg <= baud_cnt_reg + 1'b1;
      end

      case (state_reg)
        IDLE, STOP: begin
          if (byte_ready) begin
            if (byte_valid) begin
              state_reg   <= START;
              tx_reg      <= 1'b0;
              shift_reg   <= tx_byte;
              bit_idx_reg <= '0;
`ifdef PUF_UART_PARITY_EN
              parity_reg  <= ^tx_byte;
`endif
            end else begin
              state_reg <= IDLE;
              tx_reg    <= 1'b1;
            end
          end
        end
        START: begin
          if (baud_tick) begin
            state_reg <= DATA;
            tx_reg    <= shift_reg[0];
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_idx_reg == 3'd7) begin
`ifdef PUF_UART_PARITY_EN
              state_reg <= PARITY;
              tx_reg    <= parity_reg;
`else
              state_reg <= STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
              shift_reg   <= {1'b0, shift_reg[7:1]};
              tx_reg      <= shift_reg[1];
            end
          end
        end
`ifdef PUF_UART_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            state_reg <= STOP;
            tx_reg    <= 1'b1;
          end
        end
`endif
        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/puf_uart_framer.sv
// Buffers PUF response words in a FIFO and streams each one MSB byte first over UART.
// Optional even parity per frame via PUF_UART_PARITY_EN (handled in uart_tx_core).
module puf_uart_framer
  import puf_uart_pkg::*;
#(
  parameter int RESP_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_DIV   = 1250
) (
  input  logic                          clk,
  input  logic                          reset_btn,
  input  logic [RESP_WIDTH-1:0]         resp_data,
  input  logic                          resp_valid,
  output logic                          resp_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int BPW = bytes_per_word(RESP_WIDTH);
  localparam int IW  = $clog2(BPW + 1);

  logic [RESP_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [LW-1:0]         level_reg;
  ser_state_t            word_state_reg;
  logic [RESP_WIDTH-1:0] word_reg;
  logic [IW-1:0]         byte_idx_reg;

  logic [RESP_WIDTH-1:0] head_word;
  logic                  push;
  logic                  pop;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [7:0]            tx_byte;

  assign resp_ready = (level_reg != LW'(FIFO_DEPTH));
  assign push       = resp_valid && resp_ready;
  assign pop        = (word_state_reg == LOAD);
  assign head_word  = fifo_mem[rd_ptr_reg];
  assign fifo_level = level_reg;
  assign busy       = (word_state_reg != IDLE) || (level_reg != '0);

  // The first byte goes straight from the FIFO head during LOAD so the start bit lands one edge later.
  always_comb begin
    byte_valid = 1'b0;
    tx_byte    = word_reg[RESP_WIDTH-1 -: UART_BITS];
    if (word_state_reg == LOAD) begin
      byte_valid = 1'b1;
      tx_byte    = head_word[RESP_WIDTH-1 -: UART_BITS];
    end else if (word_state_reg == DATA) begin
      byte_valid = (byte_idx_reg != IW'(BPW));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= resp_data;
    end
  end

  // DATA here means "word in flight": remaining bytes are fed to the core as it frees up.
  always_ff @(posedge clk or posedge reset_btn) begin
    if (reset_btn) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      word_state_reg <= IDLE;
      word_reg       <= '0;
      byte_idx_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase

      case (word_state_reg)
        IDLE: begin
          if (level_reg != '0) begin
            word_state_reg <= LOAD;
          end
        end
        LOAD: begin
          word_reg       <= head_word << UART_BITS;
          byte_idx_reg   <= IW'(1);
          word_state_reg <= DATA;
        end
        DATA: begin
          if (byte_valid && byte_ready) begin
            word_reg     <= word_reg << UART_BITS;
            byte_idx_reg <= byte_idx_reg + 1'b1;
          end else if (byte_ready) begin
            word_state_reg <= IDLE;
          end
        end
        default: word_state_reg <= IDLE;
      endcase
    end
  end

  uart_tx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx_core (
    .clk        (clk),
    .reset_btn  (reset_btn),
    .tx_byte    (tx_byte),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .uart_tx    (uart_tx)
  );

endmodule

// File: tb/tb_puf_uart_framer.sv
// Directed bench for puf_uart_framer: latency, exact waveform, FIFO fill/wrap, mid-frame reset, random traffic.
module tb_puf_uart_framer;

  localparam int RW = 16;
  localparam int FD = 4;
  localparam int BD = 4;
`ifdef PUF_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic          clk = 1'b0;
  logic          reset_btn = 1'b1;
  logic [RW-1:0] resp_data = '0;
  logic          resp_valid = 1'b0;
  logic          resp_ready;
  logic          uart_tx;
  logic          busy;
  logic [2:0]    fifo_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_count = 0;
  logic [7:0] exp_q[$];
  int start_q[$];

  puf_uart_framer #(
    .RESP_WIDTH (RW),
    .FIFO_DEPTH (FD),
    .BAUD_DIV   (BD)
  ) dut (
    .clk        (clk),
    .reset_btn  (reset_btn),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge reset_btn) rst_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    if (p == FRAME_BITS - 1) return 1'b1;
    return ^b;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [RW-1:0] w);
    int n;
    n = 0;
    resp_data  = w;
    resp_valid = 1'b1;
    while (!resp_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!resp_ready) begin
      check("push_timeout", n, 0);
      resp_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    resp_valid = 1'b0;
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    $display("push 0x%04h level %0d", w, fifo_level);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", (n < 6000), 1);
  endtask

  // UART receiver model sampling each bit at its centre.
  initial begin
    logic [7:0] d;
    logic sb, pb, stb;
    int rc;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_btn && uart_tx === 1'b0) begin
        rc = rst_count;
        start_q.push_back(cyc);
        repeat (2) @(negedge clk);
        sb = uart_tx;
        for (int b = 0; b < 8; b++) begin
          repeat (BD) @(negedge clk);
          d[b] = uart_tx;
        end
`ifdef PUF_UART_PARITY_EN
        repeat (BD) @(negedge clk);
        pb = uart_tx;
`endif
        repeat (BD) @(negedge clk);
        stb = uart_tx;
        @(negedge clk);
        if (rc == rst_count) begin
          check("rx_start", sb, 0);
          check("rx_stop", stb, 1);
`ifdef PUF_UART_PARITY_EN
          check("rx_parity", pb, ^d);
`endif
          if (exp_q.size() == 0) begin
            check("rx_extra_byte", exp_q.size(), 1);
          end else begin
            check("rx_byte", d, exp_q.pop_front());
            $display("rx 0x%02h", d);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wb [2];
    logic [3:0] samp;
    int lv [5];
    logic [RW-1:0] fill_w [6];
    int exp_gap;

    // Reset state
    repeat (3) @(posedge clk); #1;
    check("rst_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", resp_ready, 1);
    @(negedge clk) reset_btn = 1'b0;
    @(posedge clk); #1;

    // Latency and exact waveform of 0xA53C
    push(16'hA53C);
    check("lat_n_tx", uart_tx, 1);
    check("lat_n_level", fifo_level, 1);
    @(posedge clk); #1;
    check("lat_n1_tx", uart_tx, 1);
    @(posedge clk); #1;
    check("lat_n2_tx", uart_tx, 0);
    check("lat_n2_level", fifo_level, 0);
    wb[0] = 8'hA5;
    wb[1] = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < FRAME_BITS; p++) begin
        for (int c = 0; c < BD; c++) begin
          if (!(i == 0 && p == 0 && c == 0)) begin
            @(posedge clk); #1;
          end
          samp[c] = uart_tx;
        end
        check($sformatf("wave_b%0d_p%0d", i, p), samp, {4{exp_bit(wb[i], p)}});
      end
    end
    @(posedge clk); #1;
    check("post_word_tx", uart_tx, 1);
    check("post_word_busy", busy, 0);

    // Data changes without handshake are ignored
    repeat (5) begin
      resp_data = RW'($urandom);
      @(posedge clk); #1;
    end
    check("nohs_level", fifo_level, 0);
    check("nohs_busy", busy, 0);
    check("nohs_tx", uart_tx, 1);

    // Fill the FIFO, including a push coinciding with the LOAD pop, and wrap pointers
    start_q.delete();
    lv = '{1, 2, 2, 3, 4};
    fill_w = '{16'h0102, 16'h1F2E, 16'h3D4C, 16'h5B6A, 16'h7988, 16'h97A6};
    for (int k = 0; k < 5; k++) begin
      push(fill_w[k]);
      check($sformatf("fill_level_%0d", k), fifo_level, lv[k]);
    end
    check("fill_ready_full", resp_ready, 0);
    push(fill_w[5]);
    check("fill_level_5", fifo_level, 4);
    check("fill_ready_5", resp_ready, 0);
    wait_idle();
    check("fill_frames", start_q.size(), 12);
    for (int i = 1; i < 12 && i < start_q.size(); i++) begin
      exp_gap = (i % 2 == 1) ? FRAME_BITS * BD : FRAME_BITS * BD + 2;
      check($sformatf("frame_spacing_%0d", i), start_q[i] - start_q[i-1], exp_gap);
    end

    // Reset during bit 3 of the second byte
    @(posedge clk); #1;
    push(16'h1234);
    push(16'h5678);
    @(posedge clk); #1;
    check("mid_start_tx", uart_tx, 0);
    repeat (FRAME_BITS * BD + 17) @(posedge clk);
    #2;
    check("mid_bit3_tx", uart_tx, 0);
    check("mid_busy", busy, 1);
    reset_btn = 1'b1;
    #1;
    check("mid_rst_tx", uart_tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_level", fifo_level, 0);
    @(posedge clk); #1;
    check("mid_rst_level_next", fifo_level, 0);
    check("mid_rst_busy_next", busy, 0);
    @(negedge clk);
    reset_btn = 1'b0;
    exp_q.delete();
    repeat (60) @(posedge clk);
    #1;
    check("post_rst_tx", uart_tx, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_level", fifo_level, 0);

    // Random traffic through the receiver model
    for (int k = 0; k < 24; k++) begin
      push(RW'($urandom));
    end
    wait_idle();
    check("rand_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
